sat_block_stats: RTL and testbench
==================================

# sat_block_stats

- Block-statistics stage directly downstream of the saturation filter.
- Consumes the filter's registered sample stream (data, valid, overflow flag) and groups valid samples into fixed-length blocks.
- For each block it reports the sum, the peak value and the number of saturated samples through a valid/ready output register.
- Collection never stalls; a completed block that cannot be handed off is dropped and counted.

## Interface
- DATA_W, 4, sample width; must equal the filter's DATA_W.
- BLOCK_LEN, 8, samples per block; power of two, >= 2.
- SUM_W, DATA_W + $clog2(BLOCK_LEN), derived localparam, sum width.
- CNT_W, $clog2(BLOCK_LEN+1), derived localparam, overflow-count width.
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- clear  input  1  synchronous; discards the partial block.
- in_data  input  DATA_W  sample; connects to the filter's out_data.
- in_valid  input  1  sample qualifier; connects to the filter's out_valid.
- in_ovf  input  1  sample was saturated; connects to the filter's ovf.
- out_sum  output  SUM_W  block sum, unsigned.
- out_max  output  DATA_W  largest sample in the block.
- out_ovf_cnt  output  CNT_W  saturated samples in the block.
- out_valid  output  1  result register holds an untransferred result.
- out_ready  input  1  consumer accepts the result.
- drop  output  1  one-cycle pulse: a completed block was discarded.
- drop_cnt  output  8  total dropped blocks; saturates at 255.

## Operation
- Accumulator registers: acc_sum, acc_max, acc_ovf and sample index idx (0..BLOCK_LEN-1). All reset to 0.
- Accepted sample: in_valid===1 at a rising edge. in_ovf is sampled only when in_valid is high.
- For a non-final accepted sample (idx < BLOCK_LEN-1):
  - acc_sum += in_data.
  - acc_max = max(acc_max, in_data).
  - acc_ovf += in_ovf.
  - idx++.
- For the final accepted sample (idx == BLOCK_LEN-1), the block completes:
  - The candidate result is acc_sum+in_data, max(acc_max,in_data), acc_ovf+in_ovf, i.e. it includes that sample.
  - The accumulator and idx return to 0 on the same edge.
- Result-register FSM:
  - EMPTY (out_valid=0): on block complete, load the candidate and go to FULL.
  - FULL (out_valid=1):
    - out_ready=1 with no completion: go to EMPTY.
    - out_ready=1 with completion on the same edge: load the new candidate and stay FULL; no drop.
    - out_ready=0 with completion: keep the old result, pulse drop, increment drop_cnt (saturating at 255), and discard the candidate.
    - out_ready=0 with no completion: hold.
- While out_valid=1 and out_ready=0, out_sum, out_max and out_ovf_cnt are stable.
- When out_valid=0, out_sum, out_max and out_ovf_cnt are 0.
- clear=1:
  - The accumulator and idx go to 0, and an in_valid sample on the same edge is ignored.
  - The result register, handshake, drop_cnt and out_ready handling are unaffected.
- Arithmetic:
  - Unsigned throughout; widths are sized so no overflow is possible.
  - Max sum is BLOCK_LEN*(2^DATA_W-1). It fits SUM_W because BLOCK_LEN is a power of two.
- Gaps in in_valid of any length pause collection; partial-block state is retained.

## Timing
- Reset values (asynchronous, immediate): out_sum=0, out_max=0, out_ovf_cnt=0, out_valid=0, drop=0, drop_cnt=0, idx=0. The FSM is in EMPTY.
- Latency: out_valid rises 1 cycle after the edge that accepted the final sample of a block.
- Throughput: one sample per cycle sustained with no gaps. The next block can complete at the earliest BLOCK_LEN cycles later.
- drop is high for exactly the cycle after the discarding edge.
- Reset asserted mid-block or with out_valid=1 loses all state. Collection restarts at idx=0 on the first edge after reset deasserts.

## Test plan
All scenarios use DATA_W=4, BLOCK_LEN=4.
- Reset values: hold rst for 3 cycles -> all outputs 0; after release out_valid stays 0 with in_valid=0.
- Basic block: samples 3,8,1,8 with ovf 0,1,0,1 back-to-back, out_ready=1 -> out_valid high for one cycle, 1 cycle after the 4th sample; out_sum=20, out_max=8, out_ovf_cnt=2.
- Gapped input: same four samples with 2 idle cycles between each -> identical result; out_valid rises 1 cycle after the 4th sample.
- Backpressure/drop: out_ready=0, feed two full blocks (all 5s, then all 2s) ->
  - out_sum stays 20;
  - drop pulses once and drop_cnt=1;
  - then raise out_ready -> one transfer of sum 20, and out_valid falls.
- Simultaneous transfer and completion: out_valid=1 and out_ready=1 on the edge that completes block 7,7,7,7 -> new result sum=28, max=7 loaded; no drop; out_valid stays high.
- Clear and async reset:
  - 2 samples, clear, then 4 samples of 1 -> sum=4.
  - Assert rst mid-block with out_valid=1 -> outputs 0 immediately, without waiting for a clock edge.
  - After release, the next 4 samples form a fresh block.

Source files
------------

// File: rtl/sat_block_stats.sv
// sat_block_stats: groups filtered samples into fixed-length blocks and reports
// the sum, the peak and the saturated-sample count of each block.
//   clk, rst      : rising-edge clock, asynchronous active-high reset
//   clear         : synchronously discards the partial block
//   in_data/in_valid/in_ovf : sample stream from the saturation filter
//   out_sum/out_max/out_ovf_cnt/out_valid/out_ready : result register handshake
//   drop/drop_cnt : discarded-block pulse and saturating 8-bit total
module sat_block_stats #(
    parameter int DATA_W    = 4,
    parameter int BLOCK_LEN = 8,
    localparam int SUM_W    = DATA_W + $clog2(BLOCK_LEN),
    localparam int CNT_W    = $clog2(BLOCK_LEN + 1),
    localparam int IDX_W    = $clog2(BLOCK_LEN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_ovf,
    output logic [SUM_W-1:0]  out_sum,
    output logic [DATA_W-1:0] out_max,
    output logic [CNT_W-1:0]  out_ovf_cnt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              drop,
    output logic [7:0]        drop_cnt
);
    typedef enum logic {EMPTY, FULL} state_t;

    state_t            r_state;
    logic [SUM_W-1:0]  r_acc_sum, r_sum;
    logic [DATA_W-1:0] r_acc_max, r_max;
    logic [CNT_W-1:0]  r_acc_ovf, r_ovf_cnt;
    logic [IDX_W-1:0]  r_idx;
    logic              r_drop;
    logic [7:0]        r_drop_cnt;

    logic              w_acc, w_last;
    logic [SUM_W-1:0]  w_sum;
    logic [DATA_W-1:0] w_max;
    logic [CNT_W-1:0]  w_ovf;

    // clear takes priority over a same-edge sample
    assign w_acc  = in_valid && !clear;
    assign w_last = w_acc && (r_idx == IDX_W'(BLOCK_LEN - 1));
    // candidate result always includes the current sample
    assign w_sum  = r_acc_sum + SUM_W'(in_data);
    assign w_max  = (in_data > r_acc_max) ? in_data : r_acc_max;
    assign w_ovf  = r_acc_ovf + CNT_W'(in_ovf);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc_sum <= '0;
            r_acc_max <= '0;
            r_acc_ovf <= '0;
            r_idx     <= '0;
        end else if (clear || w_last) begin
            r_acc_sum <= '0;
            r_acc_max <= '0;
            r_acc_ovf <= '0;
            r_idx     <= '0;
        end else if (w_acc) begin
            r_acc_sum <= w_sum;
            r_acc_max <= w_max;
            r_acc_ovf <= w_ovf;
            r_idx     <= r_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= EMPTY;
            r_sum      <= '0;
            r_max      <= '0;
            r_ovf_cnt  <= '0;
            r_drop     <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            r_drop <= 1'b0;
            case (r_state)
                EMPTY: begin
                    if (w_last) begin
                        r_state   <= FULL;
                        r_sum     <= w_sum;
                        r_max     <= w_max;
                        r_ovf_cnt <= w_ovf;
                    end
                end
                FULL: begin
                    if (out_ready && w_last) begin
                        r_sum     <= w_sum;
                        r_max     <= w_max;
                        r_ovf_cnt <= w_ovf;
                    end else if (out_ready) begin
                        // outputs read as zero while nothing is held
                        r_state   <= EMPTY;
                        r_sum     <= '0;
                        r_max     <= '0;
                        r_ovf_cnt <= '0;
                    end else if (w_last) begin
                        r_drop <= 1'b1;
                        if (r_drop_cnt != 8'hFF)
                            r_drop_cnt <= r_drop_cnt + 8'd1;
                    end
                end
                default: r_state <= EMPTY;
            endcase
        end
    end

    assign out_sum     = r_sum;
    assign out_max     = r_max;
    assign out_ovf_cnt = r_ovf_cnt;
    assign out_valid   = (r_state == FULL);
    assign drop        = r_drop;
    assign drop_cnt    = r_drop_cnt;
endmodule

// File: tb/tb_sat_block_stats.sv
// tb_sat_block_stats: directed self-checking bench for sat_block_stats (DATA_W=4, BLOCK_LEN=4).
module tb_sat_block_stats;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear = 1'b0;
    logic [3:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ovf = 1'b0;
    logic [5:0] out_sum;
    logic [3:0] out_max;
    logic [2:0] out_ovf_cnt;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       drop;
    logic [7:0] drop_cnt;
    int         n_pass = 0;
    int         n_total = 0;

    sat_block_stats #(.DATA_W(4), .BLOCK_LEN(4)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .in_data(in_data), .in_valid(in_valid), .in_ovf(in_ovf),
        .out_sum(out_sum), .out_max(out_max), .out_ovf_cnt(out_ovf_cnt),
        .out_valid(out_valid), .out_ready(out_ready),
        .drop(drop), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic put(input logic [3:0] d, input logic o);
        in_data  = d;
        in_ovf   = o;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_ovf   = 1'b0;
    endtask

    task automatic chk_res(input string tag, input int v, input int s, input int m, input int c);
        check({tag, "_valid"}, out_valid, v);
        check({tag, "_sum"}, out_sum, s);
        check({tag, "_max"}, out_max, m);
        check({tag, "_ovf"}, out_ovf_cnt, c);
    endtask

    initial begin
        idle(3);
        chk_res("rst", 0, 0, 0, 0);
        check("rst_drop", drop, 0);
        check("rst_dcnt", drop_cnt, 0);
        rst = 1'b0;
        idle(2);
        check("post_rst_valid", out_valid, 0);

        put(3, 0); put(8, 1); put(1, 0);
        check("basic_pre_valid", out_valid, 0);
        put(8, 1);
        chk_res("basic", 1, 20, 8, 2);
        idle(1);
        chk_res("basic_xfer", 0, 0, 0, 0);

        put(3, 0); idle(2); put(8, 1); idle(2); put(1, 0); idle(2);
        check("gap_pre_valid", out_valid, 0);
        put(8, 1);
        chk_res("gap", 1, 20, 8, 2);
        idle(1);
        check("gap_xfer_valid", out_valid, 0);

        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) put(5, 0);
        chk_res("bp_first", 1, 20, 5, 0);
        check("bp_first_drop", drop, 0);
        for (int i = 0; i < 4; i++) put(2, 0);
        check("bp_drop", drop, 1);
        check("bp_dcnt", drop_cnt, 1);
        chk_res("bp_hold", 1, 20, 5, 0);
        idle(1);
        check("bp_drop_pulse", drop, 0);
        check("bp_hold2_sum", out_sum, 20);
        out_ready = 1'b1;
        idle(1);
        check("bp_xfer_valid", out_valid, 0);
        check("bp_dcnt_keep", drop_cnt, 1);

        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) put(1, 0);
        chk_res("sim_first", 1, 4, 1, 0);
        put(7, 0); put(7, 0); put(7, 1);
        check("sim_hold_sum", out_sum, 4);
        out_ready = 1'b1;
        put(7, 0);
        chk_res("sim_new", 1, 28, 7, 1);
        check("sim_nodrop", drop, 0);
        check("sim_dcnt", drop_cnt, 1);
        idle(1);
        check("sim_xfer_valid", out_valid, 0);

        put(9, 0); put(9, 1);
        clear = 1'b1;
        put(15, 1);
        clear = 1'b0;
        put(1, 0); put(1, 0); put(1, 0);
        check("clr_pre_valid", out_valid, 0);
        put(1, 0);
        chk_res("clr", 1, 4, 1, 0);
        idle(1);

        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) put(3, 0);
        chk_res("ar_pre", 1, 12, 3, 0);
        put(15, 1); put(15, 1);
        #2 rst = 1'b1;
        #1;
        chk_res("ar_async", 0, 0, 0, 0);
        check("ar_dcnt", drop_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        put(5, 0); put(6, 1); put(7, 0);
        check("fresh_pre_valid", out_valid, 0);
        put(8, 0);
        chk_res("fresh", 1, 26, 8, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
